life_array_host: RTL

Host-side controller for the 16x16 Life array: it drives the array's row-write, row-read and step interface. It accepts a 16-row pattern over a valid/ready input stream and writes it into the array one row per cycle. It then issues a programmed number of generation steps and streams the resulting 16 rows back out over a valid/ready output stream. It sits between the system-side data path and the array, and is the only block that drives the array's control inputs.

---
 rtl/life_array_host.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/life_array_host.sv
// rtl/life_array_host.sv - host controller that loads, steps and reads back the 16x16 Life array
module life_array_host #(
    parameter int ROWS     = 16,
    parameter int WIDTH    = 16,
    parameter int GEN_W    = 8,
    parameter int STEP_GAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [GEN_W-1:0] gens,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] arr_vali,
    output logic [3:0]       arr_vali_selector,
    output logic             arr_write_enb,
    output logic             arr_step,
    output logic [3:0]       arr_valo_selector,
    input  logic [WIDTH-1:0] arr_valo
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_RDSEL = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [3:0] GAP_LAST = 4'((STEP_GAP > 0) ? (STEP_GAP - 1) : 0);

    logic [2:0]       state;
    logic [3:0]       row;
    logic [GEN_W-1:0] gen_rem;
    logic [3:0]       gap_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            row               <= 4'd0;
            gen_rem           <= '0;
            gap_cnt           <= 4'd0;
            in_ready          <= 1'b0;
            out_data          <= '0;
            out_valid         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            arr_vali          <= '0;
            arr_vali_selector <= 4'd0;
            arr_write_enb     <= 1'b0;
            arr_step          <= 1'b0;
            arr_valo_selector <= 4'd0;
        end else begin
            arr_write_enb <= 1'b0;
            arr_step      <= 1'b0;
            done          <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        gen_rem  <= gens;
                        row      <= 4'd0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        arr_vali          <= in_data;
                        arr_vali_selector <= row;
                        arr_write_enb     <= 1'b1;
                        if (row == LAST_ROW) begin
                            in_ready <= 1'b0;
                            row      <= 4'd0;
                            if (gen_rem != '0) begin
                                state <= S_STEP;
                            end else begin
                                state             <= S_RDSEL;
                                arr_valo_selector <= 4'd0;
                            end
                        end else begin
                            row <= row + 4'd1;
                        end
                    end
                end
                S_STEP: begin
                    arr_step <= 1'b1;
                    gen_rem  <= gen_rem - GEN_W'(1);
                    if (STEP_GAP > 0) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LAST;
                    end else if (gen_rem != GEN_W'(1)) begin
                        state <= S_STEP;
                    end else begin
                        state             <= S_RDSEL;
                        arr_valo_selector <= row;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        if (gen_rem != '0) begin
                            state <= S_STEP;
                        end else begin
                            state             <= S_RDSEL;
                            arr_valo_selector <= row;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_RDSEL: begin
                    // The array only settles after a pending step or write strobe has been taken.
                    if (!arr_step && !arr_write_enb) begin
                        out_data  <= arr_valo;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (row != LAST_ROW) begin
                            row               <= row + 4'd1;
                            arr_valo_selector <= row + 4'd1;
                            state             <= S_RDSEL;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
